direct_cache_controller: RTL and testbench
==========================================

Name: direct_cache_controller

Overview:
- Cache-side FSM that drives the existing 1024-entry tag array and the cache data array from the other end of their read/write ports.
- Services one CPU read or write at a time: reads the tag, compares it, and declares hit or miss.
- Read miss: refills the line from main RAM over a req/ack handshake, then writes the data and tag arrays.
- Writes: write-through, no-write-allocate. Sits between the CPU request port and the RAM interface.

Parameters:
- TAG_W, 3, tag width; matches the tag-array word.
- INDEX_W, 10, line index width; 2^INDEX_W lines.
- DATA_W, 8, word width; one word per line.
- CNT_W, 16, width of the hit/miss statistic counters.

Ports:
- globalclock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  request; held high until cpu_done.
- cpu_we  in  1  1=write, 0=read; sampled with cpu_req.
- cpu_addr  in  TAG_W+INDEX_W  {tag, index}.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data; valid while cpu_done is high.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_hit  out  1  hit flag, valid with cpu_done.
- tag_addr  out  INDEX_W  tag-array address.
- tag_wr_en  out  1  tag-array write enable.
- tag_in  out  TAG_W  tag write data.
- tag_out  in  TAG_W  tag-array read data; combinational from tag_addr.
- data_addr  out  INDEX_W  data-array address.
- data_wr_en  out  1  data-array write enable.
- data_in  out  DATA_W  data write data.
- data_out  in  DATA_W  data-array read data; combinational.
- ram_req  out  1  RAM request; held until ram_ack.
- ram_we  out  1  RAM write.
- ram_addr  out  TAG_W+INDEX_W  RAM word address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; valid with ram_ack.
- ram_ack  in  1  one-cycle RAM completion.
- hit_count  out  CNT_W  saturating hit counter.
- miss_count  out  CNT_W  saturating miss counter.

Behaviour:
- Reset (async, reset=1):
  - State = IDLE.
  - All outputs 0: cpu_done, cpu_hit, cpu_rdata, ram_req, ram_we, tag_wr_en, data_wr_en, both counters.
  - Registered request fields cleared.
- Reset mid-operation: same effect. An in-flight RAM transfer is abandoned and ram_req drops immediately. A later stray ram_ack is ignored because the FSM is in IDLE.
- States: IDLE, COMPARE, RAM_RD, RAM_WR, FILL, DONE.
- IDLE:
  - When cpu_req=1, latch cpu_we/cpu_addr/cpu_wdata and go to COMPARE.
  - tag_addr/data_addr are driven from the latched index in every non-IDLE state.
- COMPARE:
  - hit = (tag_out == latched tag), qualified by the optional valid bit.
  - Read hit: register cpu_rdata <= data_out, set hit flag, go to DONE.
  - Read miss: go to RAM_RD.
  - Write: if hit, assert data_wr_en with data_in = wdata in this cycle. Go to RAM_WR in both cases; a miss does not touch the tag or data arrays.
- RAM_RD:
  - ram_req=1, ram_we=0, ram_addr = latched address.
  - On ram_ack: capture ram_rdata into cpu_rdata and the fill register, go to FILL.
- FILL:
  - Exactly one cycle with tag_wr_en=1 (tag_in = latched tag) and data_wr_en=1 (data_in = fill data).
  - Go to DONE with hit flag 0.
- RAM_WR:
  - ram_req=1, ram_we=1, ram_wdata = latched wdata.
  - On ram_ack, go to DONE.
- DONE: cpu_done=1 for one cycle, then IDLE.
- cpu_req is ignored outside IDLE.
- If the CPU holds cpu_req high after cpu_done, the next request is accepted on the following IDLE cycle.
- Latency, measured from the edge that samples cpu_req:
  - Read hit: cpu_done high 2 cycles later.
  - Read miss: 3 cycles + RAM wait.
  - Write: 2 cycles + RAM wait.
- ram_ack in the same cycle as entering RAM_RD/RAM_WR is accepted.
- hit_count/miss_count:
  - Increment in COMPARE, for reads and writes.
  - Saturate at 2^CNT_W-1 with no wrap.
- ram_req/ram_we are registered outputs and change only on state transitions.

Optional Feature:
- Macro: CACHE_VALID_BITS_EN.
- Defined:
  - Internal 2^INDEX_W-bit valid vector, cleared by reset.
  - Bit set in FILL.
  - hit requires valid[index] & tag match.
- Undefined:
  - No valid vector; hit = tag match only.
  - After reset, every tag-0 address hits the zeroed arrays. This is the accepted behaviour for that build.

Decomposition:
- Shared package cache_pkg:
  - Parameters TAG_W/INDEX_W/DATA_W.
  - ADDR_W = TAG_W+INDEX_W.
  - State enum encoding.
  - Address field-extract helpers.
- One natural sub-module: sat_counter (CNT_W, inc, async reset), instantiated twice for hit/miss.

Test Plan:
- Reset then read 0x0A5 (tag 0, index 0xA5):
  - Without macro: hit, rdata 0x00, done 2 cycles after the request is sampled.
  - With macro: miss, ram_req asserted.
- Read miss 0x1C03, RAM acks after 3 cycles with 0x5A:
  - cpu_rdata 0x5A, cpu_hit 0.
  - Tag array [0x003] = 7, data array [0x003] = 0x5A.
  - miss_count 1.
- Repeat read 0x1C03: hit, rdata 0x5A, no ram_req, hit_count 1.
- Write 0x1C03 = 0x33 (hit):
  - data_wr_en in COMPARE.
  - RAM write of 0x33 to 0x1C03.
  - Following read returns 0x33 as a hit.
- Write 0x0403 = 0x77 (miss):
  - RAM write only; tag array [0x003] stays 7.
  - Following read 0x1C03 still hits with 0x33.
- Assert reset during RAM_RD with ram_req high:
  - ram_req drops asynchronously; state IDLE; counters 0.
  - Late ram_ack causes no array write.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache controller.
//   - Geometry: TAG_W / INDEX_W / DATA_W and the derived ADDR_W.
//   - cacheState_t: controller FSM state encoding.
//   - addrTag / addrIndex: split a {tag, index} CPU address into its fields.
package cache_pkg;

  localparam int TAG_W   = 3;
  localparam int INDEX_W = 10;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = TAG_W + INDEX_W;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COMPARE = 3'd1,
    RAM_RD  = 3'd2,
    RAM_WR  = 3'd3,
    FILL    = 3'd4,
    DONE    = 3'd5
  } cacheState_t;

  function automatic logic [TAG_W-1:0] addrTag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:INDEX_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addrIndex(input logic [ADDR_W-1:0] addr);
    return addr[INDEX_W-1:0];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the cache hit/miss statistics.
// Ports:
//   globalclock - system clock, rising edge
//   reset       - asynchronous active-high reset, clears the count
//   inc         - increment request for this cycle
//   count       - current value; sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             globalclock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge globalclock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/direct_cache_controller.sv
// Direct-mapped, write-through / no-write-allocate cache controller.
// Drives an external tag array and data array (combinational read ports)
// and refills read misses from main RAM over a req/ack handshake.
//
// Ports:
//   globalclock, reset         - clock (rising edge), async active-high reset
//   cpu_req/we/addr/wdata      - CPU request, held until cpu_done
//   cpu_rdata/done/hit         - one-cycle completion pulse with read data / hit flag
//   tag_addr/wr_en/in, tag_out - tag-array port
//   data_addr/wr_en/in, data_out - data-array port
//   ram_req/we/addr/wdata      - RAM request, held until ram_ack
//   ram_rdata, ram_ack         - RAM response
//   hit_count, miss_count      - saturating statistics
//
// Build option: define CACHE_VALID_BITS_EN to add a per-line valid vector.
// Without it a hit is a pure tag match, so tag-0 addresses hit the
// zero-initialised arrays after reset.
module direct_cache_controller
  import cache_pkg::*;
#(
  parameter int TAG_W   = cache_pkg::TAG_W,
  parameter int INDEX_W = cache_pkg::INDEX_W,
  parameter int DATA_W  = cache_pkg::DATA_W,
  parameter int CNT_W   = 16
) (
  input  logic                     globalclock,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [TAG_W+INDEX_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     cpu_done,
  output logic                     cpu_hit,
  output logic [INDEX_W-1:0]       tag_addr,
  output logic                     tag_wr_en,
  output logic [TAG_W-1:0]         tag_in,
  input  logic [TAG_W-1:0]         tag_out,
  output logic [INDEX_W-1:0]       data_addr,
  output logic                     data_wr_en,
  output logic [DATA_W-1:0]        data_in,
  input  logic [DATA_W-1:0]        data_out,
  output logic                     ram_req,
  output logic                     ram_we,
  output logic [TAG_W+INDEX_W-1:0] ram_addr,
  output logic [DATA_W-1:0]        ram_wdata,
  input  logic [DATA_W-1:0]        ram_rdata,
  input  logic                     ram_ack,
  output logic [CNT_W-1:0]         hit_count,
  output logic [CNT_W-1:0]         miss_count
);

  cacheState_t state, nextState;

  logic                     reqWe;
  logic [TAG_W+INDEX_W-1:0] reqAddr;
  logic [DATA_W-1:0]        reqWdata;
  logic [DATA_W-1:0]        fillData;
  logic [DATA_W-1:0]        rdataReg;
  logic                     hitReg;
  logic                     ramReqReg;
  logic                     ramWeReg;
  logic [TAG_W-1:0]         reqTag;
  logic [INDEX_W-1:0]       reqIndex;
  logic                     tagMatch;
  logic                     lineHit;
  logic                     hitInc;
  logic                     missInc;

  assign reqTag   = addrTag(reqAddr);
  assign reqIndex = addrIndex(reqAddr);
  assign tagMatch = (tag_out == reqTag);

`ifdef CACHE_VALID_BITS_EN
  logic [(2**INDEX_W)-1:0] validBits;

  // A line becomes valid only once it has been refilled from RAM.
  always_ff @(posedge globalclock or posedge reset) begin
    if (reset) begin
      validBits <= '0;
    end else if (state == FILL) begin
      validBits[reqIndex] <= 1'b1;
    end
  end

  assign lineHit = tagMatch & validBits[reqIndex];
`else
  assign lineHit = tagMatch;
`endif

  // State register
  always_ff @(posedge globalclock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (cpu_req) nextState = COMPARE;
      COMPARE: begin
        if (reqWe)        nextState = RAM_WR;
        else if (lineHit) nextState = DONE;
        else              nextState = RAM_RD;
      end
      RAM_RD:  if (ram_ack) nextState = FILL;
      RAM_WR:  if (ram_ack) nextState = DONE;
      FILL:    nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Request latch, result registers and registered RAM handshake.
  // ram_req/ram_we are computed from nextState so they only move with
  // state transitions and drop together with the async reset.
  always_ff @(posedge globalclock or posedge reset) begin
    if (reset) begin
      reqWe     <= 1'b0;
      reqAddr   <= '0;
      reqWdata  <= '0;
      fillData  <= '0;
      rdataReg  <= '0;
      hitReg    <= 1'b0;
      ramReqReg <= 1'b0;
      ramWeReg  <= 1'b0;
    end else begin
      ramReqReg <= (nextState == RAM_RD) || (nextState == RAM_WR);
      ramWeReg  <= (nextState == RAM_WR);
      case (state)
        IDLE: begin
          if (cpu_req) begin
            reqWe    <= cpu_we;
            reqAddr  <= cpu_addr;
            reqWdata <= cpu_wdata;
          end
        end
        COMPARE: begin
          hitReg <= lineHit;
          if (!reqWe && lineHit) rdataReg <= data_out;
        end
        RAM_RD: begin
          if (ram_ack) begin
            rdataReg <= ram_rdata;
            fillData <= ram_rdata;
          end
        end
        FILL:    hitReg <= 1'b0;
        default: ;
      endcase
    end
  end

  // Array-side outputs and completion pulse
  always_comb begin
    cpu_done   = 1'b0;
    tag_addr   = '0;
    data_addr  = '0;
    tag_wr_en  = 1'b0;
    tag_in     = '0;
    data_wr_en = 1'b0;
    data_in    = '0;
    if (state != IDLE) begin
      tag_addr  = reqIndex;
      data_addr = reqIndex;
    end
    case (state)
      COMPARE: begin
        // Write hit updates the cached copy; a write miss leaves the arrays alone.
        if (reqWe && lineHit) begin
          data_wr_en = 1'b1;
          data_in    = reqWdata;
        end
      end
      FILL: begin
        tag_wr_en  = 1'b1;
        tag_in     = reqTag;
        data_wr_en = 1'b1;
        data_in    = fillData;
      end
      DONE:    cpu_done = 1'b1;
      default: ;
    endcase
  end

  assign cpu_rdata = rdataReg;
  assign cpu_hit   = hitReg;
  assign ram_req   = ramReqReg;
  assign ram_we    = ramWeReg;
  assign ram_addr  = reqAddr;
  assign ram_wdata = reqWdata;

  assign hitInc  = (state == COMPARE) &  lineHit;
  assign missInc = (state == COMPARE) & ~lineHit;

  sat_counter #(.CNT_W(CNT_W)) hitCounter (
    .globalclock (globalclock),
    .reset       (reset),
    .inc         (hitInc),
    .count       (hit_count)
  );

  sat_counter #(.CNT_W(CNT_W)) missCounter (
    .globalclock (globalclock),
    .reset       (reset),
    .inc         (missInc),
    .count       (miss_count)
  );

endmodule

// File: tb/tb_direct_cache_controller.sv
// Directed bench for direct_cache_controller: models the tag/data arrays and
// a RAM responder, and checks each step against hand-computed values.
module tb_direct_cache_controller;
  import cache_pkg::*;

  logic        globalclock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_done, cpu_hit;
  logic [9:0]  tag_addr, data_addr;
  logic        tag_wr_en, data_wr_en;
  logic [2:0]  tag_in, tag_out;
  logic [7:0]  data_in, data_out;
  logic        ram_req, ram_we, ram_ack;
  logic [12:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;
  logic [15:0] hit_count, miss_count;

  logic        satInc;
  logic [2:0]  satCount;

  logic [2:0]  tagMem  [1024];
  logic [7:0]  dataMem [1024];
  logic        memClear;
  int          tagWrites, dataWrites;

  int          vectors = 0;
  int          miscompares = 0;
  int          expHits = 0;
  int          expMiss = 0;

  int          rDone, rWrEn;
  logic [7:0]  rRdata, rReqWdata;
  logic        rHit, rSawReq, rReqWe;
  logic [12:0] rReqAddr;

  always #5 globalclock = ~globalclock;

  direct_cache_controller dut (
    .globalclock (globalclock),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_done    (cpu_done),
    .cpu_hit     (cpu_hit),
    .tag_addr    (tag_addr),
    .tag_wr_en   (tag_wr_en),
    .tag_in      (tag_in),
    .tag_out     (tag_out),
    .data_addr   (data_addr),
    .data_wr_en  (data_wr_en),
    .data_in     (data_in),
    .data_out    (data_out),
    .ram_req     (ram_req),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .ram_ack     (ram_ack),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  sat_counter #(.CNT_W(3)) satDut (
    .globalclock (globalclock),
    .reset       (reset),
    .inc         (satInc),
    .count       (satCount)
  );

  // Tag/data array model: combinational read, synchronous write.
  assign tag_out  = tagMem[tag_addr];
  assign data_out = dataMem[data_addr];

  always @(posedge globalclock) begin
    if (memClear) begin
      for (int i = 0; i < 1024; i++) begin
        tagMem[i]  <= 3'd0;
        dataMem[i] <= 8'd0;
      end
      tagWrites  <= 0;
      dataWrites <= 0;
    end else begin
      if (tag_wr_en) begin
        tagMem[tag_addr] <= tag_in;
        tagWrites        <= tagWrites + 1;
      end
      if (data_wr_en) begin
        dataMem[data_addr] <= data_in;
        dataWrites         <= dataWrites + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One CPU access. Cycle c counts rising edges after the request is driven
  // (c=1 is the edge that samples cpu_req); observations happen on falling edges.
  // The RAM acks ackDelay cycles after it first sees ram_req.
  task automatic access(input logic we, input logic [12:0] addr, input logic [7:0] wd,
                        input int ackDelay, input logic [7:0] rd);
    int reqCycles;
    reqCycles = 0;
    rDone = -1; rWrEn = -1; rSawReq = 1'b0; rReqWe = 1'b0;
    rReqAddr = '0; rReqWdata = '0; rRdata = '0; rHit = 1'b0;
    @(negedge globalclock);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    for (int c = 1; c <= 40; c++) begin
      @(negedge globalclock);
      ram_ack = 1'b0;
      if (data_wr_en) rWrEn = c;
      if (cpu_done) begin
        rDone  = c;
        rRdata = cpu_rdata;
        rHit   = cpu_hit;
        break;
      end
      if (ram_req) begin
        rSawReq   = 1'b1;
        rReqWe    = ram_we;
        rReqAddr  = ram_addr;
        rReqWdata = ram_wdata;
        if (reqCycles == ackDelay) begin
          ram_ack   = 1'b1;
          ram_rdata = rd;
        end
        reqCycles++;
      end
    end
    cpu_req = 1'b0;
    ram_ack = 1'b0;
  endtask

  initial begin
    int wrSnap;
    logic seenReq;
    reset = 1'b1; memClear = 1'b1; satInc = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ram_ack = 1'b0; ram_rdata = '0;
    repeat (3) @(negedge globalclock);

    // Reset state
    check("rst_done",   32'(cpu_done),   32'd0);
    check("rst_hit",    32'(cpu_hit),    32'd0);
    check("rst_rdata",  32'(cpu_rdata),  32'd0);
    check("rst_ramreq", 32'(ram_req),    32'd0);
    check("rst_ramwe",  32'(ram_we),     32'd0);
    check("rst_tagwe",  32'(tag_wr_en),  32'd0);
    check("rst_datawe", 32'(data_wr_en), 32'd0);
    check("rst_hits",   32'(hit_count),  32'd0);
    check("rst_misses", 32'(miss_count), 32'd0);
    reset = 1'b0; memClear = 1'b0;

    // Counter saturation on a 3-bit instance
    satInc = 1'b1;
    repeat (3) @(negedge globalclock);
    check("sat_three", 32'(satCount), 32'd3);
    repeat (7) @(negedge globalclock);
    check("sat_hold",  32'(satCount), 32'd7);
    satInc = 1'b0;

    // Read 0x0A5 right after reset
    access(1'b0, 13'h00A5, 8'h00, 0, 8'h11);
`ifdef CACHE_VALID_BITS_EN
    expMiss++;
    check("a5_hit",    32'(rHit),    32'd0);
    check("a5_ramreq", 32'(rSawReq), 32'd1);
    check("a5_rdata",  32'(rRdata),  32'h11);
    check("a5_lat",    32'(rDone),   32'd4);
`else
    expHits++;
    check("a5_hit",    32'(rHit),    32'd1);
    check("a5_ramreq", 32'(rSawReq), 32'd0);
    check("a5_rdata",  32'(rRdata),  32'h00);
    check("a5_lat",    32'(rDone),   32'd2);
`endif

    // Read miss 0x1C03 (tag 7, index 3), RAM answers 0x5A after 3 cycles
    access(1'b0, 13'h1C03, 8'h00, 3, 8'h5A);
    expMiss++;
    check("rm_rdata",  32'(rRdata),     32'h5A);
    check("rm_hit",    32'(rHit),       32'd0);
    check("rm_lat",    32'(rDone),      32'd7);
    check("rm_ramwe",  32'(rReqWe),     32'd0);
    check("rm_addr",   32'(rReqAddr),   32'h1C03);
    check("rm_tag",    32'(tagMem[3]),  32'd7);
    check("rm_data",   32'(dataMem[3]), 32'h5A);
    check("rm_misses", 32'(miss_count), 32'(expMiss));

    // Repeat read: hit
    access(1'b0, 13'h1C03, 8'h00, 0, 8'hEE);
    expHits++;
    check("rh_hit",    32'(rHit),      32'd1);
    check("rh_rdata",  32'(rRdata),    32'h5A);
    check("rh_ramreq", 32'(rSawReq),   32'd0);
    check("rh_lat",    32'(rDone),     32'd2);
    check("rh_hits",   32'(hit_count), 32'(expHits));

    // Write hit 0x1C03 = 0x33, RAM acks after 1 cycle
    access(1'b1, 13'h1C03, 8'h33, 1, 8'h00);
    expHits++;
    check("wh_wren",   32'(rWrEn),      32'd1);
    check("wh_ramwe",  32'(rReqWe),     32'd1);
    check("wh_addr",   32'(rReqAddr),   32'h1C03);
    check("wh_wdata",  32'(rReqWdata),  32'h33);
    check("wh_lat",    32'(rDone),      32'd4);
    check("wh_hit",    32'(rHit),       32'd1);
    check("wh_data",   32'(dataMem[3]), 32'h33);
    check("wh_hits",   32'(hit_count),  32'(expHits));
    access(1'b0, 13'h1C03, 8'h00, 0, 8'hEE);
    expHits++;
    check("wh_rd_hit",   32'(rHit),   32'd1);
    check("wh_rd_rdata", 32'(rRdata), 32'h33);

    // Write miss 0x0403 (tag 1, index 3) = 0x77: RAM only
    access(1'b1, 13'h0403, 8'h77, 0, 8'h00);
    expMiss++;
    check("wm_wren",   32'(rWrEn),      32'hFFFF_FFFF);
    check("wm_ramwe",  32'(rReqWe),     32'd1);
    check("wm_addr",   32'(rReqAddr),   32'h0403);
    check("wm_wdata",  32'(rReqWdata),  32'h77);
    check("wm_lat",    32'(rDone),      32'd3);
    check("wm_hit",    32'(rHit),       32'd0);
    check("wm_tag",    32'(tagMem[3]),  32'd7);
    check("wm_data",   32'(dataMem[3]), 32'h33);
    check("wm_misses", 32'(miss_count), 32'(expMiss));
    access(1'b0, 13'h1C03, 8'h00, 0, 8'hEE);
    expHits++;
    check("wm_rd_hit",   32'(rHit),      32'd1);
    check("wm_rd_rdata", 32'(rRdata),    32'h33);
    check("wm_rd_hits",  32'(hit_count), 32'(expHits));

    // Reset while a refill of 0x0805 (tag 2, index 5) waits in RAM_RD
    @(negedge globalclock);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0805;
    seenReq = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge globalclock);
      if (ram_req) begin
        seenReq = 1'b1;
        break;
      end
    end
    check("ar_reqseen", 32'(seenReq), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("ar_ramreq", 32'(ram_req),    32'd0);
    check("ar_state",  32'(dut.state),  32'(IDLE));
    check("ar_hits",   32'(hit_count),  32'd0);
    check("ar_misses", 32'(miss_count), 32'd0);
    wrSnap = tagWrites + dataWrites;
    @(negedge globalclock);
    reset = 1'b0; cpu_req = 1'b0;
    ram_ack = 1'b1; ram_rdata = 8'hC3;
    @(negedge globalclock);
    ram_ack = 1'b0;
    repeat (3) @(negedge globalclock);
    check("ar_nowrite", 32'(tagWrites + dataWrites), 32'(wrSnap));
    check("ar_tag5",    32'(tagMem[5]),  32'd0);
    check("ar_idle",    32'(dut.state),  32'(IDLE));
    check("ar_ramreq2", 32'(ram_req),    32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
